// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory port: access sizes, FSM states,
// address widths and small alignment helpers.
package lsu_pkg;

    localparam int ADDR_W  = 16;
    localparam int WADDR_W = 14;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // Size code 2'b11 falls through to the word case everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    align_lo = lo;
            SZ_H:    align_lo = {lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store lane mask and replication, load lane select and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (addr_lo)
            2'b00:   rd_byte = rdata[7:0];
            2'b01:   rd_byte = rdata[15:8];
            2'b10:   rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        lane_mask   = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rdata;
        case (size)
            SZ_B: begin
                lane_mask   = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = is_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_H: begin
                lane_mask   = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = is_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            default: begin
                lane_mask   = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dm_port.sv
// Load/store unit port to the data cache. Define LSU_MISALIGN_TRAP_EN to trap
// misaligned accesses; otherwise they are silently aligned down.
//
//   state     | meaning
//   ST_IDLE   | ready for a request, dm_* enables low
//   ST_ACCESS | cache access presented, held while dm_miss is high
//   ST_RESP   | one-cycle resp_valid pulse, then back to idle
module lsu_dm_port
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_ren,
    output logic [13:0] dm_addr,
    output logic [3:0]  dm_ben,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_miss
);

    lsu_state_t  state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lo_q;
    logic        err_q;
    logic        req_trap;
    logic [1:0]  req_lo;

    logic [1:0]  al_size;
    logic [1:0]  al_lo;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_trap = is_misaligned(req_size, req_addr[1:0]);
`else
    assign req_trap = 1'b0;
`endif

    // Flop stays 0 in the default build because req_trap is constant there.
    assign resp_err = err_q;
    assign req_lo   = align_lo(req_size, req_addr[1:0]);

    // Idle: lanes come from the incoming request; access: from the latched one.
    assign al_size = (state == ST_IDLE) ? req_size : size_q;
    assign al_lo   = (state == ST_IDLE) ? req_lo   : lo_q;

    lsu_align u_align (
        .size        (al_size),
        .addr_lo     (al_lo),
        .is_unsigned (uns_q),
        .wdata       (req_wdata),
        .rdata       (dm_rdata),
        .lane_mask   (al_mask),
        .wdata_lanes (al_wdata),
        .rdata_ext   (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            err_q      <= 1'b0;
            dm_ren     <= 1'b0;
            dm_ben     <= 4'b0;
            dm_addr    <= 14'b0;
            dm_wdata   <= 32'b0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_B;
            lo_q       <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        size_q    <= req_size;
                        lo_q      <= req_lo;
                        req_ready <= 1'b0;
                        if (req_trap) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'b0;
                            err_q      <= 1'b1;
                        end else begin
                            state    <= ST_ACCESS;
                            dm_ren   <= !req_we;
                            dm_ben   <= req_we ? al_mask : 4'b0000;
                            dm_addr  <= req_addr[15:2];
                            dm_wdata <= al_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!dm_miss) begin
                        state      <= ST_RESP;
                        dm_ren     <= 1'b0;
                        dm_ben     <= 4'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? 32'b0 : al_rdata;
                        err_q      <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    err_q      <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    err_q      <= 1'b0;
                    dm_ren     <= 1'b0;
                    dm_ben     <= 4'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dm_port.sv
// Directed bench for lsu_dm_port; expected values are hand-computed per scenario.
module tb_lsu_dm_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_ren;
    logic [13:0] dm_addr;
    logic [3:0]  dm_ben;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_miss;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_dm_port dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dm_ren       (dm_ren),
        .dm_addr      (dm_addr),
        .dm_ben       (dm_ben),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_miss      (dm_miss)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current (idle) cycle; returns at cycle N+1.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [15:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) $display("FAIL rst_resp got v=%b e=%b exp 0/0", resp_valid, resp_err); else n_pass++;
        n_checks++; if (dm_ren !== 1'b0 || dm_ben !== 4'b0) $display("FAIL rst_dm_en got ren=%b ben=%b exp 0/0000", dm_ren, dm_ben); else n_pass++;
        n_checks++; if (resp_rdata !== 32'h0 || dm_addr !== 14'h0 || dm_wdata !== 32'h0) $display("FAIL rst_data got r=%h a=%h w=%h exp zeros", resp_rdata, dm_addr, dm_wdata); else n_pass++;
        step();
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready_idle got %b exp 1", req_ready); else n_pass++;
    endtask

    task automatic test_word_store();
        dm_miss = 1'b0;
        issue(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF);
        n_checks++; if (dm_addr !== 14'h0004) $display("FAIL ws_addr got %h exp 0004", dm_addr); else n_pass++;
        n_checks++; if (dm_ben !== 4'b1111 || dm_ren !== 1'b0) $display("FAIL ws_en got ben=%b ren=%b exp 1111/0", dm_ben, dm_ren); else n_pass++;
        n_checks++; if (dm_wdata !== 32'hDEADBEEF) $display("FAIL ws_wdata got %h exp deadbeef", dm_wdata); else n_pass++;
        n_checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) $display("FAIL ws_n1 got rdy=%b v=%b exp 0/0", req_ready, resp_valid); else n_pass++;
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) $display("FAIL ws_resp got v=%b r=%h e=%b exp 1/0/0", resp_valid, resp_rdata, resp_err); else n_pass++;
        n_checks++; if (dm_ben !== 4'b0000) $display("FAIL ws_ben_off got %b exp 0000", dm_ben); else n_pass++;
        step();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL ws_n3 got v=%b rdy=%b exp 0/1", resp_valid, req_ready); else n_pass++;
    endtask

    task automatic test_byte_load();
        dm_miss  = 1'b0;
        dm_rdata = 32'h80FF_0000;
        issue(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0);
        n_checks++; if (dm_ren !== 1'b1 || dm_ben !== 4'b0000 || dm_addr !== 14'h0004) $display("FAIL bl_access got ren=%b ben=%b a=%h exp 1/0000/0004", dm_ren, dm_ben, dm_addr); else n_pass++;
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFF80) $display("FAIL bl_signed got v=%b r=%h exp 1/ffffff80", resp_valid, resp_rdata); else n_pass++;
        step();
        issue(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0);
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000080) $display("FAIL bl_unsigned got v=%b r=%h exp 1/00000080", resp_valid, resp_rdata); else n_pass++;
        step();
        dm_rdata = 32'hCAFE_F00D;
        issue(1'b0, 2'b01, 1'b0, 16'h0002, 32'h0);
        step();
        n_checks++; if (resp_rdata !== 32'hFFFFCAFE) $display("FAIL hl_signed got %h exp ffffcafe", resp_rdata); else n_pass++;
        step();
    endtask

    task automatic test_half_store();
        dm_miss = 1'b0;
        issue(1'b1, 2'b01, 1'b0, 16'h0002, 32'h0000_1234);
        n_checks++; if (dm_ben !== 4'b1100) $display("FAIL hs_ben got %b exp 1100", dm_ben); else n_pass++;
        n_checks++; if (dm_wdata !== 32'h12341234) $display("FAIL hs_wdata got %h exp 12341234", dm_wdata); else n_pass++;
        step();
        step();
        issue(1'b1, 2'b00, 1'b0, 16'h0001, 32'h0000_00A7);
        n_checks++; if (dm_ben !== 4'b0010 || dm_wdata !== 32'hA7A7A7A7) $display("FAIL bs_lanes got ben=%b w=%h exp 0010/a7a7a7a7", dm_ben, dm_wdata); else n_pass++;
        step();
        step();
    endtask

    task automatic test_miss_hold();
        int held_bad;
        held_bad = 0;
        dm_miss  = 1'b1;
        dm_rdata = 32'h1122_3344;
        issue(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (dm_ren !== 1'b1 || dm_addr !== 14'h0008 || dm_ben !== 4'b0000 || resp_valid !== 1'b0) held_bad++;
            step();
        end
        n_checks++; if (held_bad !== 0) $display("FAIL miss_hold got %0d bad cycles exp 0", held_bad); else n_pass++;
        dm_miss = 1'b0;
        n_checks++; if (resp_valid !== 1'b0 || dm_ren !== 1'b1) $display("FAIL miss_n6 got v=%b ren=%b exp 0/1", resp_valid, dm_ren); else n_pass++;
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11223344) $display("FAIL miss_n7 got v=%b r=%h exp 1/11223344", resp_valid, resp_rdata); else n_pass++;
        step();
    endtask

    task automatic test_misaligned();
        dm_miss  = 1'b0;
        dm_rdata = 32'hCAFE_F00D;
        issue(1'b0, 2'b10, 1'b0, 16'h0001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) $display("FAIL mis_trap got v=%b e=%b r=%h exp 1/1/0", resp_valid, resp_err, resp_rdata); else n_pass++;
        n_checks++; if (dm_ren !== 1'b0 || dm_ben !== 4'b0) $display("FAIL mis_nodm got ren=%b ben=%b exp 0/0000", dm_ren, dm_ben); else n_pass++;
        step();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL mis_after got v=%b rdy=%b exp 0/1", resp_valid, req_ready); else n_pass++;
`else
        n_checks++; if (dm_ren !== 1'b1 || dm_addr !== 14'h0000) $display("FAIL mis_align got ren=%b a=%h exp 1/0000", dm_ren, dm_addr); else n_pass++;
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hCAFEF00D) $display("FAIL mis_word got v=%b e=%b r=%h exp 1/0/cafef00d", resp_valid, resp_err, resp_rdata); else n_pass++;
        step();
        issue(1'b0, 2'b01, 1'b1, 16'h0003, 32'h0);
        step();
        n_checks++; if (resp_rdata !== 32'h0000CAFE || resp_err !== 1'b0) $display("FAIL mis_half got r=%h e=%b exp 0000cafe/0", resp_rdata, resp_err); else n_pass++;
        step();
`endif
    endtask

    task automatic test_back_to_back();
        dm_miss      = 1'b0;
        dm_rdata     = 32'h0BAD_F00D;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 16'h0100;
        req_wdata    = 32'h0;
        step();
        step();
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL b2b_first got v=%b exp 1", resp_valid); else n_pass++;
        step();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_gap got v=%b rdy=%b exp 0/1", resp_valid, req_ready); else n_pass++;
        step();
        req_valid = 1'b0;
        n_checks++; if (dm_ren !== 1'b1 || dm_addr !== 14'h0040) $display("FAIL b2b_second got ren=%b a=%h exp 1/0040", dm_ren, dm_addr); else n_pass++;
        step();
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADF00D) $display("FAIL b2b_resp got v=%b r=%h exp 1/0badf00d", resp_valid, resp_rdata); else n_pass++;
        step();
    endtask

    task automatic test_reset_in_access();
        int spurious;
        spurious = 0;
        dm_miss  = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 16'h0040, 32'hA5A5A5A5);
        n_checks++; if (dm_ben !== 4'b1111) $display("FAIL ra_pre got ben=%b exp 1111", dm_ben); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++; if (dm_ben !== 4'b0000 || dm_ren !== 1'b0 || resp_valid !== 1'b0) $display("FAIL ra_drop got ben=%b ren=%b v=%b exp 0000/0/0", dm_ben, dm_ren, resp_valid); else n_pass++;
        reset   = 1'b0;
        dm_miss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) spurious++;
            step();
        end
        n_checks++; if (spurious !== 0) $display("FAIL ra_after got %0d bad cycles exp 0", spurious); else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 16'h0;
        req_wdata    = 32'h0;
        dm_rdata     = 32'h0;
        dm_miss      = 1'b0;
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_store();
        test_miss_hold();
        test_misaligned();
        test_back_to_back();
        test_reset_in_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t, passed %0d of %0d", $time, n_pass, n_checks);
        $fatal(1);
    end

endmodule
